fetch_stage: RTL

//  Instruction-fetch front end. Owns the PC and drives the combinational instruction ROM address.

---
 rtl/fetch_pkg.sv | 36 +++
 rtl/fetch_queue.sv | 76 +++++++
 rtl/fetch_stage.sv | 86 ++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
//------------------------------------------------------------------------------
// Module      : fetch_pkg
// Description : Shared widths, fetch-queue entry type and PC helpers.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef INSTR_WIDTH
`define INSTR_WIDTH 32
`endif
`ifndef NOP_INSTRUCTION
`define NOP_INSTRUCTION 32'h0000_0013
`endif

package fetch_pkg;

  typedef struct packed {
    logic [`DATA_WIDTH-1:0]  pc;
    logic [`INSTR_WIDTH-1:0] instr;
  } fq_entry_t;

  localparam int ENTRY_W = $bits(fq_entry_t);

  localparam logic [`DATA_WIDTH-1:0] PC_STEP = `DATA_WIDTH'(4);

  // Instruction fetch is always word aligned; the two low address bits are dropped.
  function automatic logic [`DATA_WIDTH-1:0] word_align(input logic [`DATA_WIDTH-1:0] addr);
    return addr & ~(`DATA_WIDTH'(3));
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_queue.sv
//------------------------------------------------------------------------------
// Module      : fetch_queue
// Description : Small synchronous FIFO of {pc, instr} entries with flush.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         push,
  input  logic [ENTRY_W-1:0]           push_data,
  input  logic                         pop,
  output logic [ENTRY_W-1:0]           head,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  fq_entry_t        r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_full;
  logic w_push;
  logic w_pop;

  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign empty   = (r_count == '0);
  assign count   = r_count;
  assign w_pop   = pop & ~empty;
  // A full queue accepts a push in the same cycle its head leaves.
  assign w_push  = push & ~flush & (~w_full | w_pop);
  assign head    = r_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
//------------------------------------------------------------------------------
// Module      : fetch_stage
// Description : Instruction-fetch front end: PC, ROM address, fetch queue, id handshake.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [`DATA_WIDTH-1:0] RESET_PC = 32'h0000_0000,
  parameter int                     FQ_DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic [`DATA_WIDTH-1:0]   imem_addr,
  input  logic [`INSTR_WIDTH-1:0]  imem_instr,
  input  logic                     redirect_valid,
  input  logic [`DATA_WIDTH-1:0]   redirect_pc,
  output logic                     id_valid,
  input  logic                     id_ready,
  output logic [`INSTR_WIDTH-1:0]  id_instr,
  output logic [`DATA_WIDTH-1:0]   id_pc,
  output logic [`DATA_WIDTH-1:0]   id_pc_plus4
);

  localparam int CNT_W = $clog2(FQ_DEPTH + 1);

  logic [`DATA_WIDTH-1:0] r_pc;
  logic [CNT_W-1:0]       w_count;
  logic                   w_empty;
  logic                   w_deq;
  logic                   w_enq;
  fq_entry_t              w_push_entry;
  fq_entry_t              w_head;

  assign imem_addr = r_pc;
  assign id_valid  = ~w_empty;
  assign w_deq     = id_valid & id_ready;
  assign w_enq     = ~redirect_valid & ((w_count < CNT_W'(FQ_DEPTH)) | w_deq);

  always_comb begin
    w_push_entry       = '0;
    w_push_entry.pc    = r_pc;
    w_push_entry.instr = imem_instr;
  end

  // Redirect wins over everything: the word at the current PC is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= word_align(RESET_PC);
    end else if (redirect_valid) begin
      r_pc <= word_align(redirect_pc);
    end else if (w_enq) begin
      r_pc <= r_pc + PC_STEP;
    end
  end

  fetch_queue #(
    .DEPTH (FQ_DEPTH)
  ) u_fetch_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (w_enq),
    .push_data (w_push_entry),
    .pop       (w_deq),
    .head      (w_head),
    .count     (w_count),
    .empty     (w_empty)
  );

  always_comb begin
    id_instr    = `NOP_INSTRUCTION;
    id_pc       = '0;
    id_pc_plus4 = '0;
    if (id_valid) begin
      id_instr    = w_head.instr;
      id_pc       = w_head.pc;
      id_pc_plus4 = w_head.pc + PC_STEP;
    end
  end

endmodule

`default_nettype wire
